// File: rtl/wb_stage.sv
// RV32I write-back stage: MEM/WB pipeline register, load formatting and
// write-back mux, register-file write port and a 64-bit retired-instruction counter.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic [31:0] mem_pc_plus4,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [63:0] instret,
  output logic [31:0] dbg_wb_data
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_ALU2 = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd_addr;
    wb_sel_e     wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
  } memwb_t;

  memwb_t      r_wb;
  logic        r_done;
  logic [63:0] r_instret;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb      <= '0;
      r_done    <= 1'b0;
      r_instret <= '0;
    end else if (!stall) begin
      r_wb <= '{valid:      mem_valid,
                reg_write:  mem_reg_write,
                rd_addr:    mem_rd_addr,
                wb_sel:     wb_sel_e'(mem_wb_sel),
                funct3:     mem_funct3,
                alu_result: mem_alu_result,
                read_data:  mem_read_data,
                pc_plus4:   mem_pc_plus4};
      r_done <= 1'b0;
      if (mem_valid) r_instret <= r_instret + 64'd1;
    end else if (r_wb.valid) begin
      // A held entry has already been written in its first cycle.
      r_done <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred
  // for unlisted case values.
  always_comb begin
    w_byte = r_wb.read_data[7:0];
    case (r_wb.alu_result[1:0])
      2'd1:    w_byte = r_wb.read_data[15:8];
      2'd2:    w_byte = r_wb.read_data[23:16];
      2'd3:    w_byte = r_wb.read_data[31:24];
      default: w_byte = r_wb.read_data[7:0];
    endcase
  end

  assign w_half = r_wb.alu_result[1] ? r_wb.read_data[31:16] : r_wb.read_data[15:0];

  always_comb begin
    w_load_data = r_wb.read_data;
    case (r_wb.funct3)
      F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_load_data = {24'd0, w_byte};
      F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = r_wb.read_data;
    endcase
  end

  always_comb begin
    w_wdata = r_wb.alu_result;
    case (r_wb.wb_sel)
      WB_LOAD: w_wdata = w_load_data;
      WB_PC4:  w_wdata = r_wb.pc_plus4;
      default: w_wdata = r_wb.alu_result;
    endcase
  end

  assign rf_we       = r_wb.valid & r_wb.reg_write & (r_wb.rd_addr != 5'd0) & ~r_done;
  assign rf_waddr    = r_wb.rd_addr;
  assign rf_wdata    = w_wdata;
  assign dbg_wb_data = w_wdata;
  assign instret     = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of write-back vectors plus stall and async-reset
// sequences; expected results travel through a scoreboard queue.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_pc_plus4;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] instret;
  logic [31:0] dbg_wb_data;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_read_data  (mem_read_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .instret        (instret),
    .dbg_wb_data    (dbg_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] instret;
  } exp_t;

  localparam logic [31:0] RDATA = 32'h8070_F0A5;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_instret = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic st, input vec_t v);
    stall          = st;
    mem_valid      = v.valid;
    mem_reg_write  = v.reg_write;
    mem_rd_addr    = v.rd;
    mem_wb_sel     = v.wb_sel;
    mem_funct3     = v.funct3;
    mem_alu_result = v.alu;
    mem_read_data  = RDATA;
    mem_pc_plus4   = v.pc4;
  endtask

  // Drive one instruction (stall=0) and push what the next cycle must show.
  task automatic drive(input vec_t v);
    @(negedge clk);
    set_inputs(1'b0, v);
    if (v.valid) exp_instret = exp_instret + 64'd1;
    sb.push_back('{name: v.name, we: v.exp_we, waddr: v.rd,
                   wdata: v.exp_wdata, instret: exp_instret});
  endtask

  // Pop the scoreboard and compare after the capturing edge.
  task automatic compare();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, ".we"},      {63'd0, rf_we},       {63'd0, e.we});
      check({e.name, ".waddr"},   {59'd0, rf_waddr},    {59'd0, e.waddr});
      check({e.name, ".wdata"},   {32'd0, rf_wdata},    {32'd0, e.wdata});
      check({e.name, ".dbg"},     {32'd0, dbg_wb_data}, {32'd0, e.wdata});
      check({e.name, ".instret"}, instret,              e.instret);
    end
  endtask

  // Hold the pipeline register with unrelated junk on the MEM inputs.
  task automatic stall_cycle(input string name, input logic [4:0] rd,
                             input logic [31:0] wdata);
    vec_t junk;
    junk = '{name: "junk", valid: 1'b1, reg_write: 1'b1, rd: 5'd12, wb_sel: 2'b00,
             funct3: 3'b010, alu: 32'h0000_03E7, pc4: 32'h0, exp_we: 1'b0, exp_wdata: 32'h0};
    @(negedge clk);
    set_inputs(1'b1, junk);
    sb.push_back('{name: name, we: 1'b0, waddr: rd, wdata: wdata, instret: exp_instret});
  endtask

  function automatic vec_t mk(input string name, input logic valid, input logic rw,
                              input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [31:0] alu,
                              input logic [31:0] pc4, input logic we,
                              input logic [31:0] wdata);
    return '{name: name, valid: valid, reg_write: rw, rd: rd, wb_sel: sel, funct3: f3,
             alu: alu, pc4: pc4, exp_we: we, exp_wdata: wdata};
  endfunction

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("alu_rd5",    1, 1, 5'd5,  2'b00, 3'b000, 32'd323,      32'h4444, 1, 32'd323));
    vecs.push_back(mk("lb_off0",    1, 1, 5'd10, 2'b01, 3'b000, 32'h0000_1000, 32'h4444, 1, 32'hFFFF_FFA5));
    vecs.push_back(mk("lbu_off1",   1, 1, 5'd10, 2'b01, 3'b100, 32'h0000_1001, 32'h4444, 1, 32'h0000_00F0));
    vecs.push_back(mk("lh_off2",    1, 1, 5'd11, 2'b01, 3'b001, 32'h0000_1002, 32'h4444, 1, 32'hFFFF_8070));
    vecs.push_back(mk("lhu_off0",   1, 1, 5'd11, 2'b01, 3'b101, 32'h0000_1000, 32'h4444, 1, 32'h0000_F0A5));
    vecs.push_back(mk("lw_off3",    1, 1, 5'd12, 2'b01, 3'b010, 32'h0000_1003, 32'h4444, 1, 32'h8070_F0A5));
    vecs.push_back(mk("lh_off3",    1, 1, 5'd13, 2'b01, 3'b001, 32'h0000_1003, 32'h4444, 1, 32'hFFFF_8070));
    vecs.push_back(mk("lh_off1",    1, 1, 5'd13, 2'b01, 3'b001, 32'h0000_1001, 32'h4444, 1, 32'hFFFF_F0A5));
    vecs.push_back(mk("lb_off3",    1, 1, 5'd14, 2'b01, 3'b000, 32'h0000_1003, 32'h4444, 1, 32'hFFFF_FF80));
    vecs.push_back(mk("lbu_off2",   1, 1, 5'd14, 2'b01, 3'b100, 32'h0000_1002, 32'h4444, 1, 32'h0000_0070));
    vecs.push_back(mk("f3_011",     1, 1, 5'd15, 2'b01, 3'b011, 32'h0000_1001, 32'h4444, 1, 32'h8070_F0A5));
    vecs.push_back(mk("f3_111",     1, 1, 5'd15, 2'b01, 3'b111, 32'h0000_1002, 32'h4444, 1, 32'h8070_F0A5));
    vecs.push_back(mk("write_x0",   1, 1, 5'd0,  2'b00, 3'b000, 32'd77,       32'h4444, 0, 32'd77));
    vecs.push_back(mk("jal",        1, 1, 5'd1,  2'b10, 3'b000, 32'h0000_0999, 32'h0000_0010, 1, 32'h0000_0010));
    vecs.push_back(mk("sel11_alu",  1, 1, 5'd31, 2'b11, 3'b000, 32'hDEAD_BEEF, 32'h4444, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk("alu_not_ld", 1, 1, 5'd2,  2'b00, 3'b000, 32'h0000_2001, 32'h4444, 1, 32'h0000_2001));
    vecs.push_back(mk("no_regwr",   1, 0, 5'd3,  2'b00, 3'b000, 32'd5,        32'h4444, 0, 32'd5));
    vecs.push_back(mk("bubble",     0, 1, 5'd9,  2'b00, 3'b000, 32'h0000_1234, 32'h4444, 0, 32'h0000_1234));

    rst = 1'b0;
    set_inputs(1'b0, mk("idle", 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 0, 32'h0));
    repeat (3) @(posedge clk);
    #1;
    check("reset.we",      {63'd0, rf_we},       64'd0);
    check("reset.waddr",   {59'd0, rf_waddr},    64'd0);
    check("reset.wdata",   {32'd0, rf_wdata},    64'd0);
    check("reset.dbg",     {32'd0, dbg_wb_data}, 64'd0);
    check("reset.instret", instret,              64'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      compare();
    end

    // Stall: entry written in its first cycle only, then held silently.
    drive(mk("stall_cap", 1, 1, 5'd6, 2'b00, 3'b000, 32'd123, 32'h4444, 1, 32'd123));
    compare();
    for (int k = 0; k < 3; k++) begin
      stall_cycle("stall_hold", 5'd6, 32'd123);
      compare();
    end
    drive(mk("after_stall", 1, 1, 5'd8, 2'b00, 3'b000, 32'd456, 32'h4444, 1, 32'd456));
    compare();

    // Stall with a bubble held: nothing happens, next instruction is written.
    drive(mk("bub_cap", 0, 1, 5'd4, 2'b00, 3'b000, 32'd9, 32'h4444, 0, 32'd9));
    compare();
    stall_cycle("bub_hold", 5'd4, 32'd9);
    compare();
    drive(mk("after_bub", 1, 1, 5'd4, 2'b00, 3'b000, 32'd10, 32'h4444, 1, 32'd10));
    compare();

    // Asynchronous reset between edges while a valid entry is held.
    drive(mk("pre_rst", 1, 1, 5'd7, 2'b00, 3'b000, 32'h55, 32'h4444, 1, 32'h55));
    compare();
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst.we",      {63'd0, rf_we},    64'd0);
    check("async_rst.waddr",   {59'd0, rf_waddr}, 64'd0);
    check("async_rst.wdata",   {32'd0, rf_wdata}, 64'd0);
    check("async_rst.instret", instret,           64'd0);
    exp_instret = 64'd0;
    @(posedge clk);
    #1;
    check("rst_held.we", {63'd0, rf_we}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    drive(mk("post_rst_bub", 0, 1, 5'd9, 2'b00, 3'b000, 32'h77, 32'h4444, 0, 32'h77));
    compare();
    drive(mk("post_rst_alu", 1, 1, 5'd5, 2'b00, 3'b000, 32'd323, 32'h4444, 1, 32'd323));
    compare();

    if (sb.size() != 0) check("scoreboard_leftover", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
